// File: rtl/sn_pkg.sv
// Shared types and helpers for the stochastic-number stream decoder.
package sn_pkg;

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} sn_state_e;

  localparam int SMOOTH_SHIFT = 2;
  localparam int MIN_WIN_LOG2 = 2;
  localparam int MAX_WIN_LOG2 = 12;

  // Bipolar value 2*ones - N; int keeps the 2*N intermediate from overflowing.
  function automatic int sn_bipolar(input int ones, input int win_log2);
    return 2 * ones - (1 << win_log2);
  endfunction

endpackage

// File: rtl/sn_stream_decoder_if.sv
// Bitstream input and result valid/ready port of the stream decoder.
interface sn_stream_decoder_if #(parameter int WIN_LOG2 = 7);
  logic                     sn_bit;
  logic                     sn_valid;
  logic [WIN_LOG2:0]        res_ones;
  logic signed [WIN_LOG2+1:0] res_bip;
  logic [WIN_LOG2:0]        res_smooth;
  logic                     res_valid;
  logic                     res_ready;

  modport master (
    output sn_bit, sn_valid, res_ready,
    input  res_ones, res_bip, res_smooth, res_valid
  );

  modport slave (
    input  sn_bit, sn_valid, res_ready,
    output res_ones, res_bip, res_smooth, res_valid
  );
endinterface

// File: rtl/sn_window_counter.sv
// Counts qualified bits and ones over back-to-back windows of 2^WIN_LOG2 bits.
module sn_window_counter
  import sn_pkg::*;
#(
  parameter int WIN_LOG2 = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                sn_bit,
  input  logic                sn_valid,
  output logic                win_close,
  output logic [WIN_LOG2:0]   final_ones
);

  if (WIN_LOG2 < MIN_WIN_LOG2 || WIN_LOG2 > MAX_WIN_LOG2) begin : g_bad_param
    $error("sn_window_counter: WIN_LOG2 out of range");
  end

  localparam logic [WIN_LOG2-1:0] LAST_BIT = '1;

  logic [WIN_LOG2-1:0] bit_cnt;
  logic [WIN_LOG2:0]   ones_cnt;

  // The closing bit is folded into the reported count, so ones_cnt tops out at N-1.
  assign win_close  = en && sn_valid && (bit_cnt == LAST_BIT);
  assign final_ones = ones_cnt + {{WIN_LOG2{1'b0}}, sn_bit};

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      bit_cnt  <= '0;
      ones_cnt <= '0;
    end else if (!en || win_close) begin
      bit_cnt  <= '0;
      ones_cnt <= '0;
    end else if (sn_valid) begin
      bit_cnt  <= bit_cnt + WIN_LOG2'(1);
      ones_cnt <= final_ones;
    end
  end

endmodule

// File: rtl/sn_stream_decoder.sv
// Stochastic bitstream to binary decoder: windowed ones count, bipolar value, overrun flag.
// Define SN_DECODER_SMOOTH_EN to enable the exponential smoothing of res_smooth.
module sn_stream_decoder
  import sn_pkg::*;
#(
  parameter int WIN_LOG2 = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic                clr_overrun,
  output logic                overrun,
  output logic                busy,
  sn_stream_decoder_if.slave  bus
);

  localparam int OW = WIN_LOG2 + 1;
  localparam int BW = WIN_LOG2 + 2;

  sn_state_e state_q, state_d;
  logic      accum;

  logic          win_close;
  logic [OW-1:0] final_ones;
  logic          latch, drop;

  logic [OW-1:0]        res_ones_q;
  logic signed [BW-1:0] res_bip_q;
  logic                 res_valid_q;
  logic                 overrun_q;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start && !stop) state_d = ACCUM;
      ACCUM: if (stop)           state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  assign accum = (state_q == ACCUM);
  assign busy  = accum;

  sn_window_counter #(.WIN_LOG2(WIN_LOG2)) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (accum),
    .sn_bit     (bus.sn_bit),
    .sn_valid   (bus.sn_valid),
    .win_close  (win_close),
    .final_ones (final_ones)
  );

  // A result slot being read this cycle is free for the closing window.
  assign latch = win_close && (!res_valid_q || bus.res_ready);
  assign drop  = win_close && res_valid_q && !bus.res_ready;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      res_ones_q  <= '0;
      res_bip_q   <= '0;
      res_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (latch) begin
        res_ones_q <= final_ones;
        res_bip_q  <= BW'(sn_bipolar(int'(final_ones), WIN_LOG2));
      end
      if (latch)                res_valid_q <= 1'b1;
      else if (bus.res_ready)   res_valid_q <= 1'b0;
      if (drop)                 overrun_q   <= 1'b1;
      else if (clr_overrun)     overrun_q   <= 1'b0;
    end
  end

  assign bus.res_ones  = res_ones_q;
  assign bus.res_bip   = res_bip_q;
  assign bus.res_valid = res_valid_q;
  assign overrun       = overrun_q;

`ifdef SN_DECODER_SMOOTH_EN
  logic [OW-1:0]        smooth_q;
  logic                 smooth_init_q;
  logic signed [BW-1:0] smooth_diff, smooth_step;

  assign smooth_diff = $signed({1'b0, final_ones}) - $signed({1'b0, smooth_q});
  assign smooth_step = smooth_diff >>> SMOOTH_SHIFT;

  // smooth_init_q marks that the filter has been seeded since the last start.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      smooth_q      <= '0;
      smooth_init_q <= 1'b0;
    end else begin
      if (!accum && start && !stop) smooth_init_q <= 1'b0;
      if (latch) begin
        smooth_q      <= smooth_init_q ? smooth_q + smooth_step[OW-1:0] : final_ones;
        smooth_init_q <= 1'b1;
      end
    end
  end

  assign bus.res_smooth = smooth_q;
`else
  assign bus.res_smooth = '0;
`endif

endmodule

// File: tb/tb_sn_stream_decoder.sv
// Scoreboard bench for sn_stream_decoder (WIN_LOG2=7); honours SN_DECODER_SMOOTH_EN.
module tb_sn_stream_decoder;

  localparam int W  = 7;
  localparam int OW = W + 1;
  localparam int BW = W + 2;

  logic clk = 1'b0;
  logic rst_n, start, stop, clr_overrun;
  logic overrun, busy;

  sn_stream_decoder_if #(.WIN_LOG2(W)) bus();

  sn_stream_decoder #(.WIN_LOG2(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .clr_overrun (clr_overrun),
    .overrun     (overrun),
    .busy        (busy),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  typedef struct {int ones; int bip;} exp_t;
  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  // Every consumed result is compared against the oldest expected window.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.res_valid && bus.res_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got ones=%0d bip=%0d, required no result", bus.res_ones, bus.res_bip);
      end else begin
        e = sb.pop_front();
        if (bus.res_ones !== OW'(e.ones) || bus.res_bip !== BW'(e.bip)) begin
          bad++;
          $display("FAIL sb_result: got ones=%0d bip=%0d, required ones=%0d bip=%0d",
                   bus.res_ones, bus.res_bip, e.ones, e.bip);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b);
    bus.sn_valid = 1'b1;
    bus.sn_bit   = b;
    step();
    bus.sn_valid = 1'b0;
    bus.sn_bit   = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic push(input int ones, input int bip);
    exp_t e;
    e.ones = ones;
    e.bip  = bip;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    start = 1'b0; stop = 1'b0; clr_overrun = 1'b0;
    bus.sn_bit = 1'b0; bus.sn_valid = 1'b0; bus.res_ready = 1'b0;
    step();
    step();
    total++;
    if ({bus.res_valid, overrun, busy} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags: got valid/ovr/busy=%b, required 000", {bus.res_valid, overrun, busy});
    end
    total++;
    if ({bus.res_ones, bus.res_bip, bus.res_smooth} !== '0) begin
      bad++;
      $display("FAIL reset_data: got ones=%0d bip=%0d smooth=%0d, required 0", bus.res_ones, bus.res_bip, bus.res_smooth);
    end
    rst_n = 1'b0;
    step();
  endtask

  task automatic test_all_ones();
    bus.res_ready = 1'b1;
    do_start();
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL busy_after_start: got %b, required 1", busy); end
    for (int i = 0; i < 127; i++) send(1'b1);
    total++;
    if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL early_valid: got %b, required 0", bus.res_valid); end
    push(128, 128);
    send(1'b1);
    total++;
    if (bus.res_valid !== 1'b1 || bus.res_ones !== OW'(128)) begin
      bad++;
      $display("FAIL latency: got valid=%b ones=%0d, required valid=1 ones=128", bus.res_valid, bus.res_ones);
    end
    do_stop();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL busy_after_stop: got %b, required 0", busy); end
  endtask

  task automatic test_zero_alt();
    do_start();
    push(0, -128);
    for (int i = 0; i < 128; i++) send(1'b0);
    push(64, 0);
    for (int i = 0; i < 128; i++) send(i % 2 == 0);
    do_stop();
  endtask

  task automatic test_gapped();
    do_start();
    push(32, -64);
    for (int i = 0; i < 128; i++) begin
      bus.sn_bit = 1'b1;
      step();
      step();
      send(i < 32);
    end
    do_stop();
  endtask

  task automatic test_overrun();
    bus.res_ready = 1'b0;
    do_start();
    push(10, -108);
    for (int i = 0; i < 128; i++) send(i < 10);
    total++;
    if (bus.res_valid !== 1'b1 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL ovr_first: got valid=%b ovr=%b, required valid=1 ovr=0", bus.res_valid, overrun);
    end
    for (int i = 0; i < 128; i++) send(i < 20);
    total++;
    if (bus.res_ones !== OW'(10) || overrun !== 1'b1) begin
      bad++;
      $display("FAIL ovr_drop: got ones=%0d ovr=%b, required ones=10 ovr=1", bus.res_ones, overrun);
    end
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    total++;
    if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear: got %b, required 0", overrun); end
    for (int i = 0; i < 128; i++) begin
      clr_overrun = (i == 127);
      send(i < 30);
    end
    clr_overrun = 1'b0;
    total++;
    if (overrun !== 1'b1 || bus.res_ones !== OW'(10) || bus.res_bip !== BW'(-108)) begin
      bad++;
      $display("FAIL ovr_set_dominant: got ovr=%b ones=%0d bip=%0d, required ovr=1 ones=10 bip=-108",
               overrun, bus.res_ones, bus.res_bip);
    end
    bus.res_ready = 1'b1;
    step();
    total++;
    if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL valid_fall: got %b, required 0", bus.res_valid); end
    do_stop();
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
  endtask

  task automatic test_stop();
    bus.res_ready = 1'b1;
    do_start();
    for (int i = 0; i < 50; i++) send(1'b1);
    do_stop();
    step();
    step();
    total++;
    if (busy !== 1'b0 || bus.res_valid !== 1'b0) begin
      bad++;
      $display("FAIL stop_partial: got busy=%b valid=%b, required 0 0", busy, bus.res_valid);
    end
    do_start();
    push(128, 128);
    for (int i = 0; i < 127; i++) send(1'b1);
    stop = 1'b1;
    send(1'b1);
    stop = 1'b0;
    total++;
    if (busy !== 1'b0 || bus.res_valid !== 1'b1) begin
      bad++;
      $display("FAIL stop_on_close: got busy=%b valid=%b, required busy=0 valid=1", busy, bus.res_valid);
    end
    step();
    do_start();
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL stop_wins: got busy=%b, required 0", busy); end
  endtask

  task automatic test_smooth();
    logic [OW-1:0] exp_s1, exp_s2;
`ifdef SN_DECODER_SMOOTH_EN
    exp_s1 = OW'(128);
    exp_s2 = OW'(96);
`else
    exp_s1 = '0;
    exp_s2 = '0;
`endif
    bus.res_ready = 1'b1;
    do_start();
    push(128, 128);
    for (int i = 0; i < 128; i++) send(1'b1);
    total++;
    if (bus.res_smooth !== exp_s1) begin bad++; $display("FAIL smooth_first: got %0d, required %0d", bus.res_smooth, exp_s1); end
    push(0, -128);
    for (int i = 0; i < 128; i++) send(1'b0);
    total++;
    if (bus.res_smooth !== exp_s2) begin bad++; $display("FAIL smooth_second: got %0d, required %0d", bus.res_smooth, exp_s2); end
    do_stop();
  endtask

  task automatic test_reset_mid();
    bus.res_ready = 1'b0;
    do_start();
    for (int i = 0; i < 40; i++) send(1'b1);
    rst_n = 1'b1;
    #1;
    total++;
    if ({bus.res_ones, bus.res_bip, bus.res_smooth, bus.res_valid, overrun, busy} !== '0) begin
      bad++;
      $display("FAIL async_reset: got ones=%0d bip=%0d smooth=%0d valid=%b ovr=%b busy=%b, required all 0",
               bus.res_ones, bus.res_bip, bus.res_smooth, bus.res_valid, overrun, busy);
    end
    step();
    rst_n = 1'b0;
    step();
    bus.res_ready = 1'b1;
    do_start();
    push(128, 128);
    for (int i = 0; i < 128; i++) send(1'b1);
    do_stop();
    step();
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_zero_alt();
    test_gapped();
    test_overrun();
    test_stop();
    test_smooth();
    test_reset_mid();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: got %0d pending results, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sn_stream_decoder.md
Name: sn_stream_decoder

Overview:
- Downstream stage of the stochastic multiplier: consumes the product bitstream (one SN bit per qualified cycle) and converts it back to binary.
- Counts ones over fixed windows of 2^WIN_LOG2 bits.
- Presents each window result as unipolar ones-count and bipolar signed value on a valid/ready output port.
- Flags results lost to back-pressure.

Parameters:
- WIN_LOG2, 7, log2 of window length in bits (window N = 2^WIN_LOG2); legal range 2..12.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-high (despite name).
- start  input  1  pulse: begin continuous conversion (IDLE only).
- stop  input  1  pulse: abort conversion, discard partial window.
- sn_bit  input  1  stochastic bit from multiplier.
- sn_valid  input  1  sn_bit qualifier.
- res_ones  output  WIN_LOG2+1  ones count of last window, 0..N.
- res_bip  output  WIN_LOG2+2  signed bipolar value = 2*ones - N, range -N..+N.
- res_smooth  output  WIN_LOG2+1  smoothed ones count (SMOOTH_EN), else 0.
- res_valid  output  1  result register holds unread result.
- res_ready  input  1  consumer accepts result.
- overrun  output  1  sticky: a window completed while result unread.
- clr_overrun  input  1  clears overrun.
- busy  output  1  high in ACCUM.

Behaviour:
- Reset: state IDLE; bit counter, ones counter, res_ones, res_bip, res_smooth = 0; res_valid, overrun, busy = 0.
- FSM IDLE:
  - start -> ACCUM next cycle.
  - Counters cleared on entry.
  - sn_valid ignored.
- FSM ACCUM:
  - Each sn_valid cycle: bit_cnt += 1; ones_cnt += sn_bit.
  - ones_cnt is WIN_LOG2+1 bits and never wraps (max N).
  - Window close: sn_valid while bit_cnt == N-1.
    - Closing bit is included: final = ones_cnt + sn_bit.
    - Counters restart at 0 the next cycle; no bit between windows is skipped.
    - Conversion continues until stop.
  - start in ACCUM: ignored.
  - stop in ACCUM: -> IDLE next cycle, partial window discarded; the result register, res_valid and overrun are untouched.
  - stop and start in the same cycle: stop wins.
  - stop on a window-close cycle: the closing window is still latched.
- Latch rule at window close:
  - res_valid==0, or res_valid && res_ready in the same cycle: load res_ones = final and res_bip = 2*final - N (sign-correct, full width); res_valid = 1 next cycle.
  - res_valid && !res_ready: new result dropped, old result held, overrun set.
- Output handshake:
  - res_valid falls the cycle after res_valid && res_ready, unless a simultaneous latch reloads it.
  - Outputs are stable while res_valid && !res_ready.
  - Latency: window close cycle -> res_valid high on the following edge (1 cycle).
- overrun: set-dominant over clr_overrun in the same cycle; cleared only by clr_overrun or reset.
- busy = (state == ACCUM), registered.
- Reset asserted mid-window: all state returns to reset values asynchronously.

Optional Feature:
- Macro: SN_DECODER_SMOOTH_EN.
- Defined:
  - res_smooth is updated on each latched window (not dropped ones).
  - First latched window after start loads res_smooth = final directly.
  - Later windows: res_smooth <= res_smooth + ((final - res_smooth) >>> 2), computed in signed WIN_LOG2+2 bits, truncated back to WIN_LOG2+1.
  - Result stays within 0..N.
- Undefined: res_smooth tied to 0; no smoothing logic.

Decomposition:
- Package sn_pkg:
  - state enum {IDLE, ACCUM}.
  - Function computing bipolar value from ones count and WIN_LOG2.
  - Localparam for the smoothing shift (2).
- Sub-module sn_window_counter:
  - bit_cnt/ones_cnt.
  - Window-close strobe and final count.
  - Parameterised by WIN_LOG2.
- Top holds the FSM, result register, handshake and overrun.

Test Plan (WIN_LOG2=7, N=128):
- Reset, start, 128 sn_valid cycles with sn_bit=1, res_ready=1 -> res_ones=128, res_bip=+128, res_valid high one cycle after the 128th bit.
- start, 128 bits all 0 -> res_ones=0, res_bip=-128; alternating 1/0 window -> res_ones=64, res_bip=0.
- Gapped stream: sn_valid on every 3rd cycle, 32 ones in 128 valid bits -> res_ones=32, res_bip=-64; invalid cycles not counted.
- res_ready=0 across two full windows (ones 10, then 20) -> res_ones holds 10, overrun=1; clr_overrun -> overrun=0; clr_overrun coincident with a third close -> overrun stays 1.
- stop after 50 bits -> busy=0, no new result; restart with 128 ones -> res_ones=128, so the partial window was not carried over.
- SN_DECODER_SMOOTH_EN: windows 128 then 0 -> res_smooth 128 then 96; rst_n pulsed mid-window -> all outputs 0, IDLE.
